counter_step_mod: RTL and testbench

- Parametrised successor to the team's 4-bit enable/count-by-2 counter.
- Counts up or down by a programmable step within a programmable range 0..limit.
- Supports wrap or saturate at the boundaries, parallel load, a terminal-count pulse and a sticky overflow flag.
- Used as the general-purpose event/timebase counter in activity-level designs.

---
 rtl/counter_step_mod.sv | 123 ++++++++++++
 tb/tb_counter_step_mod.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_step_mod.sv
// rtl/counter_step_mod.sv - up/down step counter with programmable range, wrap/saturate, load, tc and sticky ovf
module counter_step_mod #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              enable,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              at_zero
);

    // One extra bit so count+step and limit+1 comparisons never truncate.
    localparam int XW = WIDTH + 1;
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    // Widened views of the operands.
    logic [XW-1:0]    count_x;
    logic [XW-1:0]    limit_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    s_x;
    logic [XW-1:0]    sum_x;

    // Candidate results and the boundary-event flag for an enabled step.
    logic [WIDTH-1:0] step_res;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_wrap;
    logic [WIDTH-1:0] load_clamped;
    logic             step_evt;
    logic             advance;

    // Effective step, candidate next counts and the boundary decision.
    always_comb begin
        count_x  = {1'b0, count_q};
        limit_x  = {1'b0, limit};
        step_x   = {{(XW-STEP_W){1'b0}}, step};
        s_x      = (step_x > limit_x) ? limit_x : step_x;
        sum_x    = count_x + s_x;

        // Wrapped results fit in WIDTH bits, so modular WIDTH-bit math
        // yields the exact value once the crossing is known.
        up_wrap  = sum_x[WIDTH-1:0] - limit - ONE_W;
        dn_wrap  = count_q + limit + ONE_W - s_x[WIDTH-1:0];

        load_clamped = (load_val > limit) ? limit : load_val;
        advance      = enable && (step != '0);

        step_res = count_q;
        step_evt = 1'b0;
        if (limit == ZERO_W) begin
            // Degenerate range: pinned at zero, every advance is an event.
            step_res = ZERO_W;
            step_evt = 1'b1;
        end else if (count_x > limit_x) begin
            // Limit was lowered beneath the count: re-enter at the edge of travel.
            step_res = up ? ZERO_W : limit;
            step_evt = 1'b1;
        end else if (up) begin
            if (sum_x > limit_x) begin
                step_evt = 1'b1;
                step_res = sat ? limit : up_wrap;
            end else begin
                step_res = sum_x[WIDTH-1:0];
            end
        end else begin
            if (s_x > count_x) begin
                step_evt = 1'b1;
                step_res = sat ? ZERO_W : dn_wrap;
            end else begin
                step_res = count_q - s_x[WIDTH-1:0];
            end
        end
    end

    // Next-state selection: load beats counting, counting beats hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            count_d = load_clamped;
        end else if (advance) begin
            count_d = step_res;
            tc_d    = step_evt;
            if (step_evt) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset overriding everything.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign at_zero = (count_q == ZERO_W);

endmodule

// File: tb/tb_counter_step_mod.sv
// tb/tb_counter_step_mod.sv - table-driven directed checks for counter_step_mod
module tb_counter_step_mod;

    logic       clk;
    logic       nReset;
    logic       enable;
    logic       up;
    logic [3:0] step;
    logic       sat;
    logic [7:0] limit;
    logic       load;
    logic [7:0] load_val;
    logic       clr_ovf;
    logic [7:0] count;
    logic       tc;
    logic       ovf;
    logic       at_zero;

    int checks = 0;
    int errors = 0;

    counter_step_mod #(.WIDTH(8), .STEP_W(4)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .enable   (enable),
        .up       (up),
        .step     (step),
        .sat      (sat),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .at_zero  (at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nrst;
        logic       en;
        logic       up;
        logic [3:0] step;
        logic       sat;
        logic [7:0] limit;
        logic       ld;
        logic [7:0] ld_val;
        logic       clr;
        logic [7:0] e_count;
        logic       e_tc;
        logic       e_ovf;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic nrst, input logic en, input logic u,
                                input logic [3:0] st, input logic sa, input logic [7:0] lim,
                                input logic ld, input logic [7:0] lv, input logic clr,
                                input logic [7:0] ec, input logic etc, input logic eovf,
                                input string nm);
        vec_t v;
        v.nrst = nrst; v.en = en; v.up = u; v.step = st; v.sat = sa; v.limit = lim;
        v.ld = ld; v.ld_val = lv; v.clr = clr;
        v.e_count = ec; v.e_tc = etc; v.e_ovf = eovf; v.name = nm;
        return v;
    endfunction

    task automatic drive(input logic nrst, input logic en, input logic u, input logic [3:0] st,
                         input logic sa, input logic [7:0] lim, input logic ld,
                         input logic [7:0] lv, input logic clr);
        @(negedge clk);
        nReset = nrst; enable = en; up = u; step = st; sat = sa;
        limit = lim; load = ld; load_val = lv; clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] ec, input logic etc, input logic eovf);
        checks++;
        if (count !== ec) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", nm, count, ec);
        end
        checks++;
        if (tc !== etc) begin
            errors++;
            $display("FAIL %s tc: got %0b expected %0b", nm, tc, etc);
        end
        checks++;
        if (ovf !== eovf) begin
            errors++;
            $display("FAIL %s ovf: got %0b expected %0b", nm, ovf, eovf);
        end
        checks++;
        if (at_zero !== (ec == 8'd0)) begin
            errors++;
            $display("FAIL %s at_zero: got %0b expected %0b", nm, at_zero, (ec == 8'd0));
        end
    endtask

    initial begin
        logic [7:0] exp_c;
        logic       exp_t;
        logic       exp_o;

        nReset = 1'b0; enable = 1'b0; up = 1'b1; step = 4'd1; sat = 1'b0;
        limit = 8'd255; load = 1'b0; load_val = 8'd0; clr_ovf = 1'b0;

        //               nrst en up step sat lim  ld lv  clr  cnt tc ovf
        // reset and plain up count
        vecs.push_back(mk(0, 1, 1, 4'd1, 0, 8'd255, 0, 8'd0, 0, 8'd0, 0, 0, "rst0"));
        vecs.push_back(mk(0, 1, 1, 4'd1, 0, 8'd255, 0, 8'd0, 0, 8'd0, 0, 0, "rst1"));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 1, 1, 4'd1, 0, 8'd255, 0, 8'd0, 0, 8'(i), 0, 0, "up1"));
        vecs.push_back(mk(1, 0, 1, 4'd1, 0, 8'd255, 0, 8'd0, 0, 8'd5, 0, 0, "hold"));
        vecs.push_back(mk(1, 0, 1, 4'd1, 0, 8'd255, 0, 8'd0, 0, 8'd5, 0, 0, "hold2"));
        // wrap up limit 9 step 3
        vecs.push_back(mk(1, 0, 1, 4'd3, 0, 8'd9, 1, 8'd0, 0, 8'd0, 0, 0, "ld0"));
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 8'd9, 0, 8'd0, 0, 8'd3, 0, 0, "wrap3"));
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 8'd9, 0, 8'd0, 0, 8'd6, 0, 0, "wrap6"));
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 8'd9, 0, 8'd0, 0, 8'd9, 0, 0, "wrap9"));
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 8'd9, 0, 8'd0, 0, 8'd2, 1, 1, "wrap2"));
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 8'd9, 0, 8'd0, 0, 8'd5, 0, 1, "wrap5"));
        // saturate up, then down wrap
        vecs.push_back(mk(1, 0, 1, 4'd4, 1, 8'd9, 1, 8'd0, 0, 8'd0, 0, 1, "ld0b"));
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 8'd9, 0, 8'd0, 0, 8'd4, 0, 1, "sat4"));
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 8'd9, 0, 8'd0, 0, 8'd8, 0, 1, "sat8"));
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 8'd9, 0, 8'd0, 0, 8'd9, 1, 1, "sat9a"));
        vecs.push_back(mk(1, 1, 1, 4'd4, 1, 8'd9, 0, 8'd0, 0, 8'd9, 1, 1, "sat9b"));
        vecs.push_back(mk(1, 1, 0, 4'd4, 0, 8'd9, 0, 8'd0, 0, 8'd5, 0, 1, "dn5"));
        vecs.push_back(mk(1, 1, 0, 4'd4, 0, 8'd9, 0, 8'd0, 0, 8'd1, 0, 1, "dn1"));
        vecs.push_back(mk(1, 1, 0, 4'd4, 0, 8'd9, 0, 8'd0, 0, 8'd7, 1, 1, "dnwrap7"));
        // load priority, clamp, out-of-range entry
        vecs.push_back(mk(1, 1, 1, 4'd1, 0, 8'd20, 1, 8'd12, 0, 8'd12, 0, 1, "ld12"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 0, 8'd20, 1, 8'd50, 0, 8'd20, 0, 1, "ldclamp"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 0, 8'd10, 0, 8'd0, 0, 8'd0, 1, 1, "oor_up"));
        // ovf clear, then clear racing a wrap event
        vecs.push_back(mk(1, 0, 1, 4'd1, 0, 8'd10, 0, 8'd0, 1, 8'd0, 0, 0, "clr"));
        vecs.push_back(mk(1, 1, 0, 4'd1, 0, 8'd10, 0, 8'd0, 1, 8'd10, 1, 1, "clrrace"));
        // saturated then mid-operation reset
        vecs.push_back(mk(1, 1, 1, 4'd1, 1, 8'd10, 0, 8'd0, 0, 8'd10, 1, 1, "satA"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 1, 8'd10, 0, 8'd0, 0, 8'd10, 1, 1, "satB"));
        vecs.push_back(mk(0, 1, 1, 4'd1, 1, 8'd10, 0, 8'd0, 0, 8'd0, 0, 0, "midrst"));
        // step 0 hold, limit 0 corner
        vecs.push_back(mk(1, 1, 1, 4'd0, 0, 8'd10, 0, 8'd0, 0, 8'd0, 0, 0, "step0a"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 0, 8'd10, 0, 8'd0, 0, 8'd1, 0, 0, "step1"));
        vecs.push_back(mk(1, 1, 1, 4'd0, 0, 8'd10, 0, 8'd0, 0, 8'd1, 0, 0, "step0b"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 1, 8'd0, 0, 8'd0, 0, 8'd0, 1, 1, "lim0a"));
        vecs.push_back(mk(1, 1, 1, 4'd1, 1, 8'd0, 0, 8'd0, 0, 8'd0, 1, 1, "lim0b"));
        vecs.push_back(mk(1, 1, 0, 4'd1, 0, 8'd0, 0, 8'd0, 0, 8'd0, 1, 1, "lim0dn"));
        // step clamp 15 -> 9 with limit 9
        vecs.push_back(mk(1, 1, 1, 4'd15, 0, 8'd9, 0, 8'd0, 0, 8'd9, 0, 1, "clampA"));
        vecs.push_back(mk(1, 1, 1, 4'd15, 0, 8'd9, 0, 8'd0, 0, 8'd8, 1, 1, "clampB"));
        vecs.push_back(mk(1, 1, 0, 4'd15, 0, 8'd9, 0, 8'd0, 0, 8'd9, 1, 1, "clampDn"));
        // out-of-range entry counting down, reset beats load
        vecs.push_back(mk(1, 0, 0, 4'd1, 0, 8'd20, 1, 8'd15, 0, 8'd15, 0, 1, "ld15"));
        vecs.push_back(mk(1, 1, 0, 4'd1, 0, 8'd9, 0, 8'd0, 0, 8'd9, 1, 1, "oor_dn"));
        vecs.push_back(mk(0, 1, 1, 4'd1, 0, 8'd20, 1, 8'd5, 0, 8'd0, 0, 0, "rstld"));

        foreach (vecs[i]) begin
            drive(vecs[i].nrst, vecs[i].en, vecs[i].up, vecs[i].step, vecs[i].sat,
                  vecs[i].limit, vecs[i].ld, vecs[i].ld_val, vecs[i].clr);
            check(vecs[i].name, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_ovf);
        end

        // Long wrap run on a tiny range: tc must be a single-cycle pulse at each wrap.
        exp_c = 8'd0;
        exp_o = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 4'd1, 0, 8'd3, 0, 8'd0, 0);
            exp_t = (exp_c == 8'd3);
            exp_c = (exp_c == 8'd3) ? 8'd0 : exp_c + 8'd1;
            if (exp_t) exp_o = 1'b1;
            check("run4", exp_c, exp_t, exp_o);
        end

        // Saturated at zero counting down: event every cycle, ovf stays set under no clear.
        drive(1, 1, 0, 4'd2, 1, 8'd3, 1, 8'd1, 1);
        check("satdn_ld", 8'd1, 1'b0, 1'b0);
        drive(1, 1, 0, 4'd2, 1, 8'd3, 0, 8'd0, 0);
        check("satdn0", 8'd0, 1'b1, 1'b1);
        drive(1, 1, 0, 4'd2, 1, 8'd3, 0, 8'd0, 0);
        check("satdn1", 8'd0, 1'b1, 1'b1);
        drive(1, 0, 0, 4'd2, 1, 8'd3, 0, 8'd0, 0);
        check("satdn_idle", 8'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
